// File: rtl/rfid_reader_pkg.sv
// Shared RFID reader types: packet codes, sequencer and handshake states.
// Imported by the inventory sequencer and its command handshake.
package rfid_reader_pkg;

    localparam logic [3:0] PKT_QUERYREP = 4'd0;
    localparam logic [3:0] PKT_ACK      = 4'd1;
    localparam logic [3:0] PKT_QUERY    = 4'd2;
    localparam logic [3:0] PKT_REQRN    = 4'd6;
    localparam logic [3:0] PKT_READ     = 4'd7;

    localparam int SLOT_W = 16;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_QUERY,
        ST_QUERYREP,
        ST_ACK,
        ST_REQRN,
        ST_READ
    } seq_state_e;

    typedef enum logic [1:0] {
        HS_IDLE,
        HS_REQ,
        HS_WAIT
    } hs_state_e;

    function automatic logic [3:0] pkt_of(seq_state_e s);
        logic [3:0] p;
        case (s)
            ST_QUERY: p = PKT_QUERY;
            ST_ACK:   p = PKT_ACK;
            ST_REQRN: p = PKT_REQRN;
            ST_READ:  p = PKT_READ;
            default:  p = PKT_QUERYREP;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/rfid_cmd_handshake.sv
// start_tx / reader_running / reader_done handshake for one command.
// done is a one-cycle pulse; ok flags a valid tag reply with it.
module rfid_cmd_handshake
    import rfid_reader_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic launch,
    input  logic reader_running,
    input  logic reader_done,
    input  logic rx_packet_complete,
    output logic start_tx,
    output logic done,
    output logic ok
);

    hs_state_e hs_q, hs_d;
    logic      start_tx_q, start_tx_d;

    // done only counts once running has been seen, possibly in the same cycle
    always_comb begin
        hs_d       = hs_q;
        start_tx_d = start_tx_q;
        done       = 1'b0;
        unique case (hs_q)
            HS_IDLE: begin
                if (launch) begin
                    hs_d       = HS_REQ;
                    start_tx_d = 1'b1;
                end
            end
            HS_REQ: begin
                if (reader_running) begin
                    start_tx_d = 1'b0;
                    hs_d       = HS_WAIT;
                    if (reader_done) begin
                        hs_d = HS_IDLE;
                        done = 1'b1;
                    end
                end
            end
            HS_WAIT: begin
                if (reader_done) begin
                    hs_d = HS_IDLE;
                    done = 1'b1;
                end
            end
            default: hs_d = HS_IDLE;
        endcase
    end

    assign ok       = done & rx_packet_complete;
    assign start_tx = start_tx_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hs_q       <= HS_IDLE;
            start_tx_q <= 1'b0;
        end else begin
            hs_q       <= hs_d;
            start_tx_q <= start_tx_d;
        end
    end

endmodule

// File: rtl/rfid_inventory_sequencer.sv
// EPC inventory round sequencer: QUERY, QUERYREP, ACK, REQRN, READ.
// Define RFID_SEQ_STATS_EN to keep the tags_read/rounds counters.
module rfid_inventory_sequencer
    import rfid_reader_pkg::*;
#(
    parameter int STARTUP_CYCLES = 390,
    parameter int Q_INIT         = 2,
    parameter int MAX_RETRIES    = 3,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             reader_running,
    input  logic             reader_done,
    input  logic             rx_packet_complete,
    input  logic [15:0]      rx_handle,
    output logic [3:0]       send_packet_type,
    output logic             start_tx,
    output logic [15:0]      tx_handle,
    output logic [3:0]       slot_q,
    output logic             busy,
    output logic             round_done,
    output logic [CNT_W-1:0] tags_read,
    output logic [CNT_W-1:0] rounds
);

    localparam int SU_W = (STARTUP_CYCLES > 1) ? $clog2(STARTUP_CYCLES + 1) : 1;
    localparam int RT_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
    localparam logic [SU_W-1:0]   SU_LAST   = SU_W'(STARTUP_CYCLES - 1);
    localparam logic [RT_W-1:0]   RT_MAX    = RT_W'(MAX_RETRIES);
    localparam logic [SLOT_W-1:0] SLOT_INIT = SLOT_W'((1 << Q_INIT) - 1);

    seq_state_e        state_q, state_d, go;
    logic [SU_W-1:0]   init_cnt_q, init_cnt_d;
    logic [SLOT_W-1:0] slot_left_q, slot_left_d;
    logic [RT_W-1:0]   retry_cnt_q, retry_cnt_d;
    logic [15:0]       tx_handle_q, tx_handle_d;
    logic [3:0]        pkt_q, pkt_d;
    logic              launch_q, launch_d;
    logic              round_done_q, round_done_d;
    logic              next_slot, enter;
    logic              hs_done, hs_ok;

    rfid_cmd_handshake u_hs (
        .clk                (clk),
        .reset              (reset),
        .launch             (launch_q),
        .reader_running     (reader_running),
        .reader_done        (reader_done),
        .rx_packet_complete (rx_packet_complete),
        .start_tx           (start_tx),
        .done               (hs_done),
        .ok                 (hs_ok)
    );

    always_comb begin
        state_d      = state_q;
        init_cnt_d   = init_cnt_q;
        slot_left_d  = slot_left_q;
        retry_cnt_d  = retry_cnt_q;
        tx_handle_d  = tx_handle_q;
        pkt_d        = pkt_q;
        launch_d     = 1'b0;
        round_done_d = 1'b0;
        next_slot    = 1'b0;
        enter        = 1'b0;
        go           = ST_QUERY;
        unique case (state_q)
            ST_INIT: begin
                if (init_cnt_q == SU_LAST) begin
                    if (enable) enter = 1'b1;
                    else        state_d = ST_IDLE;
                end else begin
                    init_cnt_d = init_cnt_q + 1'b1;
                end
            end
            ST_IDLE: begin
                if (enable) enter = 1'b1;
            end
            ST_QUERY, ST_QUERYREP: begin
                if (hs_done) begin
                    if (hs_ok) begin
                        tx_handle_d = rx_handle;
                        enter       = 1'b1;
                        go          = ST_ACK;
                    end else begin
                        next_slot = 1'b1;
                    end
                end
            end
            ST_ACK, ST_REQRN, ST_READ: begin
                if (hs_done) begin
                    if (hs_ok) begin
                        tx_handle_d = rx_handle;
                        if (state_q == ST_READ) begin
                            next_slot = 1'b1;
                        end else begin
                            enter = 1'b1;
                            go    = (state_q == ST_ACK) ? ST_REQRN : ST_READ;
                        end
                    end else if (retry_cnt_q < RT_MAX) begin
                        retry_cnt_d = retry_cnt_q + 1'b1;
                        launch_d    = 1'b1;
                    end else begin
                        next_slot = 1'b1;
                    end
                end
            end
            default: state_d = ST_INIT;
        endcase

        // enable is only honoured at a round boundary
        if (next_slot) begin
            if (slot_left_q != '0) begin
                enter = 1'b1;
                go    = ST_QUERYREP;
            end else begin
                round_done_d = 1'b1;
                if (enable) enter = 1'b1;
                else        state_d = ST_IDLE;
            end
        end

        if (enter) begin
            state_d  = go;
            launch_d = 1'b1;
            pkt_d    = pkt_of(go);
            if (go == ST_QUERY)         slot_left_d = SLOT_INIT;
            else if (go == ST_QUERYREP) slot_left_d = slot_left_q - 1'b1;
        end
        if (enter || (state_d != state_q)) retry_cnt_d = '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_INIT;
            init_cnt_q   <= '0;
            slot_left_q  <= '0;
            retry_cnt_q  <= '0;
            tx_handle_q  <= '0;
            pkt_q        <= '0;
            launch_q     <= 1'b0;
            round_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            init_cnt_q   <= init_cnt_d;
            slot_left_q  <= slot_left_d;
            retry_cnt_q  <= retry_cnt_d;
            tx_handle_q  <= tx_handle_d;
            pkt_q        <= pkt_d;
            launch_q     <= launch_d;
            round_done_q <= round_done_d;
        end
    end

    assign send_packet_type = pkt_q;
    assign tx_handle        = tx_handle_q;
    assign slot_q           = 4'(Q_INIT);
    assign busy             = (state_q != ST_INIT) && (state_q != ST_IDLE);
    assign round_done       = round_done_q;

`ifdef RFID_SEQ_STATS_EN
    logic [CNT_W-1:0] tags_read_q, tags_read_d;
    logic [CNT_W-1:0] rounds_q, rounds_d;
    logic             read_ok;

    assign read_ok = (state_q == ST_READ) && hs_ok;

    always_comb begin
        tags_read_d = tags_read_q;
        rounds_d    = rounds_q;
        if (read_ok && (tags_read_q != '1)) tags_read_d = tags_read_q + 1'b1;
        if (round_done_d && (rounds_q != '1)) rounds_d = rounds_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tags_read_q <= '0;
            rounds_q    <= '0;
        end else begin
            tags_read_q <= tags_read_d;
            rounds_q    <= rounds_d;
        end
    end

    assign tags_read = tags_read_q;
    assign rounds    = rounds_q;
`else
    assign tags_read = '0;
    assign rounds    = '0;
`endif

endmodule

// File: tb/tb_rfid_inventory_sequencer.sv
// Scoreboard bench for rfid_inventory_sequencer with a scripted tag reader.
// Commands are planned up front; a monitor checks each start_tx against them.
module tb_rfid_inventory_sequencer;

    localparam logic [3:0] P_QR  = 4'd0;
    localparam logic [3:0] P_ACK = 4'd1;
    localparam logic [3:0] P_Q   = 4'd2;
    localparam logic [3:0] P_RN  = 4'd6;
    localparam logic [3:0] P_RD  = 4'd7;
`ifdef RFID_SEQ_STATS_EN
    localparam int STATS = 1;
`else
    localparam int STATS = 0;
`endif

    typedef struct { logic [3:0] pkt; logic [15:0] tx; } exp_t;
    typedef struct { logic ok; logic [15:0] h; } rep_t;

    exp_t exp_q[$];
    rep_t rep_q[$];
    int   errors  = 0;
    int   checks  = 0;
    int   pop_cnt = 0;
    int   rd_cnt  = 0;
    bit   resp_en = 1'b1;

    logic        clk, reset, enable;
    logic        reader_running, reader_done, rx_packet_complete;
    logic [15:0] rx_handle;
    logic [3:0]  send_packet_type, slot_q;
    logic        start_tx, busy, round_done;
    logic [15:0] tx_handle;
    logic [15:0] tags_read, rounds;

    rfid_inventory_sequencer dut (
        .clk                (clk),
        .reset              (reset),
        .enable             (enable),
        .reader_running     (reader_running),
        .reader_done        (reader_done),
        .rx_packet_complete (rx_packet_complete),
        .rx_handle          (rx_handle),
        .send_packet_type   (send_packet_type),
        .start_tx           (start_tx),
        .tx_handle          (tx_handle),
        .slot_q             (slot_q),
        .busy               (busy),
        .round_done         (round_done),
        .tags_read          (tags_read),
        .rounds             (rounds)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic plan(logic [3:0] p, logic [15:0] tx, logic ok, logic [15:0] h);
        exp_q.push_back('{p, tx});
        rep_q.push_back('{ok, h});
    endtask

    task automatic wait_pops(int n, string name);
        int c = 0;
        while (pop_cnt < n && c < 2000) begin
            @(negedge clk); #1;
            c++;
        end
        chk(name, 32'(pop_cnt >= n), 32'd1);
    endtask

    // scoreboard monitor
    initial begin
        logic st_prev, rd_prev;
        exp_t e;
        st_prev = 1'b0;
        rd_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (start_tx && !st_prev) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_start_tx: got pkt %0d expected none",
                             send_packet_type);
                end else begin
                    e = exp_q.pop_front();
                    pop_cnt++;
                    chk($sformatf("pkt_type#%0d", pop_cnt), 32'(send_packet_type), 32'(e.pkt));
                    chk($sformatf("tx_handle#%0d", pop_cnt), 32'(tx_handle), 32'(e.tx));
                end
            end
            if (round_done) begin
                rd_cnt++;
                chk("round_done_width", 32'(rd_prev), 32'd0);
            end
            st_prev = start_tx;
            rd_prev = round_done;
        end
    end

    // tag reader model: running pulse, then done with the planned reply
    initial begin
        rep_t r;
        reader_running     = 1'b0;
        reader_done        = 1'b0;
        rx_packet_complete = 1'b0;
        rx_handle          = 16'h0;
        forever begin
            @(negedge clk);
            if (resp_en && start_tx && !reset) begin
                reader_running = 1'b1;
                @(negedge clk);
                reader_running = 1'b0;
                repeat (2) @(negedge clk);
                r = '{1'b0, 16'h0};
                if (rep_q.size() > 0) r = rep_q.pop_front();
                rx_packet_complete = r.ok;
                rx_handle          = r.h;
                reader_done        = 1'b1;
                @(negedge clk);
                reader_done        = 1'b0;
                rx_packet_complete = 1'b0;
                rx_handle          = 16'h0;
            end
        end
    end

    initial begin
        int cyc;
        reset  = 1'b1;
        enable = 1'b1;

        // round 1: one full read, then empty slots
        plan(P_Q,   16'h0,    1'b1, 16'hBEEF);
        plan(P_ACK, 16'hBEEF, 1'b1, 16'hBEEF);
        plan(P_RN,  16'hBEEF, 1'b1, 16'hBEEF);
        plan(P_RD,  16'hBEEF, 1'b1, 16'hBEEF);
        for (int i = 0; i < 3; i++) plan(P_QR, 16'hBEEF, 1'b0, 16'h0);
        // round 2: empty
        plan(P_Q, 16'hBEEF, 1'b0, 16'h0);
        for (int i = 0; i < 3; i++) plan(P_QR, 16'hBEEF, 1'b0, 16'h0);
        // round 3: ACK exhausts its retries
        plan(P_Q, 16'hBEEF, 1'b1, 16'h1234);
        for (int i = 0; i < 4; i++) plan(P_ACK, 16'h1234, 1'b0, 16'h0);
        for (int i = 0; i < 3; i++) plan(P_QR, 16'h1234, 1'b0, 16'h0);
        // round 4: tag in slot 1, enable dropped during READ
        plan(P_Q,   16'h1234, 1'b0, 16'h0);
        plan(P_QR,  16'h1234, 1'b1, 16'hCAFE);
        plan(P_ACK, 16'hCAFE, 1'b1, 16'hCAFE);
        plan(P_RN,  16'hCAFE, 1'b1, 16'h5A5A);
        plan(P_RD,  16'h5A5A, 1'b1, 16'h5A5A);
        for (int i = 0; i < 2; i++) plan(P_QR, 16'h5A5A, 1'b0, 16'h0);

        repeat (3) @(negedge clk);
        chk("rst_start_tx", 32'(start_tx), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_round_done", 32'(round_done), 32'd0);
        chk("rst_tx_handle", 32'(tx_handle), 32'd0);
        chk("rst_pkt", 32'(send_packet_type), 32'd0);
        chk("rst_tags_read", 32'(tags_read), 32'd0);
        chk("rst_rounds", 32'(rounds), 32'd0);
        chk("slot_q", 32'(slot_q), 32'd2);

        reset = 1'b0;
        cyc = 0;
        while (!start_tx && cyc < 1000) begin
            @(negedge clk);
            cyc++;
        end
        chk("startup_cycles", 32'(cyc == 391 || cyc == 392), 32'd1);
        if (cyc != 391 && cyc != 392)
            $display("startup took %0d cycles", cyc);

        wait_pops(8, "round1_timeout");
        chk("r1_tags_read", 32'(tags_read), 32'(STATS));
        chk("r1_rounds", 32'(rounds), 32'(STATS));
        chk("r1_round_done_cnt", 32'(rd_cnt), 32'd1);
        chk("r1_tx_handle", 32'(tx_handle), 32'hBEEF);

        wait_pops(12, "round2_timeout");
        chk("r2_rounds", 32'(rounds), 32'(2 * STATS));
        chk("r2_round_done_cnt", 32'(rd_cnt), 32'd2);
        chk("r2_tags_read", 32'(tags_read), 32'(STATS));

        wait_pops(20, "round3_timeout");
        chk("r3_rounds", 32'(rounds), 32'(3 * STATS));
        chk("r3_round_done_cnt", 32'(rd_cnt), 32'd3);
        chk("r3_tx_handle", 32'(tx_handle), 32'h1234);

        wait_pops(24, "round4_read_timeout");
        enable = 1'b0;
        chk("r4_in_read", 32'(send_packet_type), 32'(P_RD));
        chk("r4_busy_in_read", 32'(busy), 32'd1);
        cyc = 0;
        while (rd_cnt < 4 && cyc < 500) begin
            @(negedge clk); #1;
            cyc++;
        end
        chk("r4_round_done_cnt", 32'(rd_cnt), 32'd4);
        repeat (60) @(negedge clk);
        chk("r4_busy", 32'(busy), 32'd0);
        chk("r4_cmd_count", 32'(pop_cnt), 32'd26);
        chk("r4_plan_left", 32'(exp_q.size()), 32'd0);
        chk("r4_rounds", 32'(rounds), 32'(4 * STATS));
        chk("r4_tags_read", 32'(tags_read), 32'(2 * STATS));
        chk("r4_start_tx_idle", 32'(start_tx), 32'd0);

        // INIT with enable low parks in IDLE, then enable starts QUERY
        resp_en = 1'b0;
        #2 reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (420) @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_start_tx", 32'(start_tx), 32'd0);
        exp_q.push_back('{P_Q, 16'h0});
        enable = 1'b1;
        cyc = 0;
        while (!start_tx && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        chk("idle_to_query", 32'(start_tx), 32'd1);
        chk("idle_to_query_lat", 32'(cyc <= 3), 32'd1);

        // asynchronous reset while start_tx is high
        #2 reset = 1'b1;
        #1;
        chk("arst_start_tx", 32'(start_tx), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_pkt", 32'(send_packet_type), 32'd0);
        chk("arst_tx_handle", 32'(tx_handle), 32'd0);
        chk("arst_rounds", 32'(rounds), 32'd0);
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rfid_inventory_sequencer.md
RFID_INVENTORY_SEQUENCER -- requirements
Module: rfid_inventory_sequencer

Interface
REQ-001 The parameter STARTUP_CYCLES SHALL default to 390 and SHALL set the clock count from reset release to the first QUERY.
REQ-002 The parameter Q_INIT SHALL default to 2 and SHALL set the slot exponent; a round SHALL contain 2^Q slots.
REQ-003 The parameter MAX_RETRIES SHALL default to 3 and SHALL set the re-sends allowed per failed ACK/REQRN/READ.
REQ-004 The parameter CNT_W SHALL default to 16 and SHALL set the statistics counter width.
REQ-005 The port clk SHALL be an input of width 1: the clock.
REQ-006 The port reset SHALL be an input of width 1: reset, asynchronous, active-high.
REQ-007 The port enable SHALL be an input of width 1: run inventory while high.
REQ-008 The port reader_running SHALL be an input of width 1: the packet engine is busy.
REQ-009 The port reader_done SHALL be an input of width 1: the packet engine finished the command and the receive window.
REQ-010 The port rx_packet_complete SHALL be an input of width 1: a valid tag reply was received; it is qualified by reader_done.
REQ-011 The port rx_handle SHALL be an input of width 16: the RN16 or handle from the last reply.
REQ-012 The port send_packet_type SHALL be an output of width 4: the command code.
REQ-013 The port start_tx SHALL be an output of width 1: the command request.
REQ-014 The port tx_handle SHALL be an output of width 16: the handle sent with ACK/REQRN/READ.
REQ-015 The port slot_q SHALL be an output of width 4: the Q sent in QUERY, equal to Q_INIT.
REQ-016 The port busy SHALL be an output of width 1: high in any state other than INIT and IDLE.
REQ-017 The port round_done SHALL be an output of width 1: a one-cycle pulse at the end of a round.
REQ-018 The port tags_read SHALL be an output of width CNT_W: the count of successful READs.
REQ-019 The port rounds SHALL be an output of width CNT_W: the count of completed rounds.

Function
REQ-020 The block SHALL implement the states INIT, IDLE, QUERY, QUERYREP, ACK, REQRN and READ.
REQ-021 In INIT the block SHALL count STARTUP_CYCLES clocks and then go to QUERY if enable is high, otherwise to IDLE.
REQ-022 In IDLE the block SHALL go to QUERY on the first cycle that enable is high.
REQ-023 Command handshake: send_packet_type SHALL be set on state entry and start_tx asserted on the next cycle.
REQ-024 The block SHALL hold start_tx high until it samples reader_running high, then drop start_tx, then wait for reader_done.
REQ-025 A command SHALL count as success when reader_done and rx_packet_complete are both high; if reader_done is high without rx_packet_complete it SHALL count as failure.
REQ-026 On each success, tx_handle SHALL be loaded from rx_handle in the same cycle.
REQ-027 QUERY SHALL load slot_left with 2^Q-1; each QUERYREP SHALL decrement slot_left.
REQ-028 On QUERY or QUERYREP success the block SHALL go to ACK, which SHALL go to REQRN, which SHALL go to READ.
REQ-029 On READ success, tags_read SHALL increment and the block SHALL go to next-slot.
REQ-030 On ACK/REQRN/READ failure the block SHALL re-send the same command while retry_cnt < MAX_RETRIES, otherwise go to next-slot.
REQ-031 retry_cnt SHALL clear on every state change.
REQ-032 Next-slot: if slot_left > 0 the block SHALL go to QUERYREP.
REQ-033 Next-slot: if slot_left = 0 the block SHALL pulse round_done, increment rounds, and go to QUERY if enable is high, otherwise to IDLE.
REQ-034 A failure in QUERY or QUERYREP SHALL be treated as next-slot.
REQ-035 When enable falls mid-command, the block SHALL finish the current command and its successors until the round ends, and only then go to IDLE.
REQ-036 The statistics counters SHALL saturate at all-ones.
REQ-037 If reader_done arrives in the same cycle as reader_running, done SHALL take precedence only after running has been seen.

Reset
REQ-038 Asynchronous reset SHALL put the block in INIT from any state, including mid-handshake.
REQ-039 On reset, start_tx, round_done, tx_handle, send_packet_type, the counters, retry_cnt and slot_left SHALL be 0, and busy SHALL be 0.

Configuration
REQ-040 With RFID_SEQ_STATS_EN defined, tags_read and rounds SHALL count as specified.
REQ-041 Without RFID_SEQ_STATS_EN, tags_read and rounds SHALL be constant 0 and their registers SHALL be omitted; sequencing SHALL be unchanged.

Structure
REQ-042 Packet codes (QUERYREP=0, ACK=1, QUERY=2, REQRN=6, READ=7) and the state enumeration SHALL live in the shared package rfid_reader_pkg.
REQ-043 The start_tx/running/done handshake SHALL be the sub-module rfid_cmd_handshake, which returns a one-cycle done pulse plus an ok flag.

Verification
REQ-044 Startup: reset released with enable=1 -> start_tx rises 391 or 392 cycles later with send_packet_type=2.
REQ-045 Full success with Q=2 and every reply carrying rx_handle=16'hBEEF -> sequence QUERY,ACK,REQRN,READ, tx_handle=16'hBEEF, tags_read=1, followed by 3 QUERYREPs.
REQ-046 Empty round with Q=2 and no replies -> 1 QUERY, 3 QUERYREPs, a single round_done pulse, rounds=1, then QUERY again.
REQ-047 ACK failing 4 times with MAX_RETRIES=3 -> ACK sent exactly 4 times, then QUERYREP.
REQ-048 Reset asserted while start_tx=1 -> start_tx=0 immediately and state=INIT.
REQ-049 enable dropped during READ of slot 1 -> remaining slots complete, round_done pulses, busy=0, and no further start_tx is issued.
